// File: rtl/gpio_controller.sv
// Memory-mapped GPIO bank: pin direction/data registers, input synchronizer,
// per-pin edge detection with write-1-to-clear pending bits and a masked interrupt.
module gpio_controller #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       gpio_address,
    input  logic [31:0]      gpio_data_i,
    input  logic [3:0]       gpio_wr,
    input  logic             gpio_enable,
    output logic [31:0]      gpio_data_o,
    output logic             gpio_ready,
    output logic             gpio_irq,
    input  logic [WIDTH-1:0] pad_data_i,
    output logic [WIDTH-1:0] pad_data_o,
    output logic [WIDTH-1:0] pad_oe
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWait
    } state_e;

    localparam logic [2:0] RegIn   = 3'd0;
    localparam logic [2:0] RegOut  = 3'd1;
    localparam logic [2:0] RegDir  = 3'd2;
    localparam logic [2:0] RegIe   = 3'd3;
    localparam logic [2:0] RegEdge = 3'd4;
    localparam logic [2:0] RegPend = 3'd5;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_ie;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_dir_next;
    logic [WIDTH-1:0] w_ie_next;
    logic [WIDTH-1:0] w_edge_next;
    logic [WIDTH-1:0] w_pend_next;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_be_mask;
    logic [31:0]      w_rdata;
    logic [2:0]       w_sel;
    logic             w_req;
    logic             w_wr_en;
    logic             w_unused;

    assign w_sel     = gpio_address[4:2];
    assign w_req     = (r_state == StIdle) && gpio_enable;
    assign w_wr_en   = w_req && (|gpio_wr);
    assign w_be_mask = {{8{gpio_wr[3]}}, {8{gpio_wr[2]}}, {8{gpio_wr[1]}}, {8{gpio_wr[0]}}};
    assign w_wmask   = w_be_mask[WIDTH-1:0];
    assign w_wdata   = gpio_data_i[WIDTH-1:0];
    assign w_unused  = &{1'b0, gpio_address[1:0], gpio_data_i, w_be_mask};

    // Edge polarity chosen per pin; detection ignores IE and DIR.
    assign w_event = (r_edge & r_s2 & ~r_s3) | (~r_edge & ~r_s2 & r_s3);

    always_comb begin
        w_out_next  = r_out;
        w_dir_next  = r_dir;
        w_ie_next   = r_ie;
        w_edge_next = r_edge;
        w_clr       = '0;
        if (w_wr_en) begin
            case (w_sel)
                RegOut:  w_out_next  = (r_out & ~w_wmask) | (w_wdata & w_wmask);
                RegDir:  w_dir_next  = (r_dir & ~w_wmask) | (w_wdata & w_wmask);
                RegIe:   w_ie_next   = (r_ie & ~w_wmask) | (w_wdata & w_wmask);
                RegEdge: w_edge_next = (r_edge & ~w_wmask) | (w_wdata & w_wmask);
                RegPend: w_clr       = w_wdata & w_wmask;
                default: ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        w_pend_next = (r_pend & ~w_clr) | w_event;
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            RegIn:   w_rdata[WIDTH-1:0] = r_s2;
            RegOut:  w_rdata[WIDTH-1:0] = r_out;
            RegDir:  w_rdata[WIDTH-1:0] = r_dir;
            RegIe:   w_rdata[WIDTH-1:0] = r_ie;
            RegEdge: w_rdata[WIDTH-1:0] = r_edge;
            RegPend: w_rdata[WIDTH-1:0] = r_pend;
            default: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (gpio_enable) w_state_next = StAck;
            StAck:   w_state_next = gpio_enable ? StWait : StIdle;
            StWait:  if (!gpio_enable) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_out   <= '0;
            r_dir   <= '0;
            r_ie    <= '0;
            r_edge  <= '0;
            r_pend  <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_dir   <= w_dir_next;
            r_ie    <= w_ie_next;
            r_edge  <= w_edge_next;
            r_pend  <= w_pend_next;
            r_s1    <= pad_data_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_irq   <= |(r_pend & r_ie);
            if (w_req) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign gpio_ready  = (r_state == StAck);
    assign gpio_data_o = gpio_ready ? r_rdata : 32'h0;
    assign gpio_irq    = r_irq;
    assign pad_data_o  = r_out;
    assign pad_oe      = r_dir;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller: bus access, pad drive, input sync,
// edge interrupts, masking, W1C collision and asynchronous reset.
module tb_gpio_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  gpio_address;
    logic [31:0] gpio_data_i;
    logic [3:0]  gpio_wr;
    logic        gpio_enable;
    logic [31:0] gpio_data_o;
    logic        gpio_ready;
    logic        gpio_irq;
    logic [31:0] pad_data_i;
    logic [31:0] pad_data_o;
    logic [31:0] pad_oe;

    int   n_checks;
    int   n_errors;
    logic irq_at_ack;
    logic [31:0] rd;

    gpio_controller #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_address (gpio_address),
        .gpio_data_i  (gpio_data_i),
        .gpio_wr      (gpio_wr),
        .gpio_enable  (gpio_enable),
        .gpio_data_o  (gpio_data_o),
        .gpio_ready   (gpio_ready),
        .gpio_irq     (gpio_irq),
        .pad_data_i   (pad_data_i),
        .pad_data_o   (pad_data_o),
        .pad_oe       (pad_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One full access: request at a falling edge, acknowledge after the next rising edge.
    task automatic bus(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] wr,
                       output logic [31:0] rdata);
        @(negedge clk);
        gpio_address = addr;
        gpio_data_i  = data;
        gpio_wr      = wr;
        gpio_enable  = 1'b1;
        @(posedge clk);
        #1;
        check("ack", {31'b0, gpio_ready}, 32'h1);
        rdata      = gpio_data_o;
        irq_at_ack = gpio_irq;
        @(negedge clk);
        gpio_enable = 1'b0;
        gpio_wr     = 4'b0;
        @(posedge clk);
        #1;
        check("ack_drop", {31'b0, gpio_ready}, 32'h0);
        check("data_zero", gpio_data_o, 32'h0);
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] wr);
        logic [31:0] dummy;
        bus(addr, data, wr, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus(addr, 32'h0, 4'b0, v);
        check(tag, v, exp);
    endtask

    initial begin
        int cnt;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        gpio_address = '0;
        gpio_data_i  = '0;
        gpio_wr      = '0;
        gpio_enable  = 1'b0;
        pad_data_i   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_oe", pad_oe, 32'h0);
        check("rst_out", pad_data_o, 32'h0);
        check("rst_irq", {31'b0, gpio_irq}, 32'h0);
        check("rst_ready", {31'b0, gpio_ready}, 32'h0);

        // Output drive with partial byte enable
        wr_reg(5'h08, 32'h0000_00FF, 4'b1111);
        wr_reg(5'h04, 32'hA5A5_A5A5, 4'b0001);
        check("pad_oe", pad_oe, 32'h0000_00FF);
        check("pad_out", pad_data_o, 32'h0000_00A5);
        rd_check("rd_out", 5'h04, 32'h0000_00A5);
        rd_check("rd_dir", 5'h08, 32'h0000_00FF);

        // Held request acknowledged once
        @(negedge clk);
        gpio_address = 5'h04;
        gpio_enable  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (gpio_ready) cnt++;
        end
        check("held_once", 32'(cnt), 32'd1);
        @(negedge clk);
        gpio_enable = 1'b0;
        @(posedge clk);

        // Reset asserted mid-cycle during the acknowledge
        @(negedge clk);
        gpio_address = 5'h08;
        gpio_data_i  = 32'h0000_0F0F;
        gpio_wr      = 4'b1111;
        gpio_enable  = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, gpio_ready}, 32'h0);
        check("mid_rst_data", gpio_data_o, 32'h0);
        check("mid_rst_oe", pad_oe, 32'h0);
        check("mid_rst_out", pad_data_o, 32'h0);
        check("mid_rst_irq", {31'b0, gpio_irq}, 32'h0);
        @(negedge clk);
        gpio_enable = 1'b0;
        gpio_wr     = 4'b0;
        rst         = 1'b0;
        // Request pending at an edge while reset is held must not commit
        @(negedge clk);
        gpio_address = 5'h04;
        gpio_data_i  = 32'hFFFF_FFFF;
        gpio_wr      = 4'b1111;
        gpio_enable  = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", {31'b0, gpio_ready}, 32'h0);
        @(negedge clk);
        gpio_enable = 1'b0;
        gpio_wr     = 4'b0;
        rst         = 1'b0;
        check("abort_out", pad_data_o, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_check("rst_rd", 5'(a * 4), 32'h0);
        end

        // Input synchronizer latency
        @(negedge clk);
        pad_data_i   = 32'h0000_1234;
        gpio_address = 5'h00;
        gpio_enable  = 1'b1;
        @(posedge clk);
        #1;
        check("in_old", gpio_data_o, 32'h0);
        @(negedge clk);
        gpio_enable = 1'b0;
        rd_check("in_new", 5'h00, 32'h0000_1234);
        rd_check("pend_rise_ignored", 5'h14, 32'h0);

        // Rising-edge interrupt on pin 3
        wr_reg(5'h10, 32'h0000_0008, 4'b1111);
        wr_reg(5'h0C, 32'h0000_0008, 4'b1111);
        @(negedge clk);
        pad_data_i = 32'h0000_123C;
        repeat (3) @(posedge clk);
        #1;
        check("irq3_not_yet", {31'b0, gpio_irq}, 32'h0);
        @(posedge clk);
        #1;
        check("irq3_set", {31'b0, gpio_irq}, 32'h1);
        rd_check("pend3", 5'h14, 32'h0000_0008);
        wr_reg(5'h14, 32'h0000_0008, 4'b1111);
        check("irq3_at_clr", {31'b0, irq_at_ack}, 32'h1);
        check("irq3_cleared", {31'b0, gpio_irq}, 32'h0);
        rd_check("pend3_clr", 5'h14, 32'h0);

        // Falling edge on pin 0 with interrupt masked
        wr_reg(5'h10, 32'h0, 4'b1111);
        wr_reg(5'h0C, 32'h0, 4'b1111);
        @(negedge clk);
        pad_data_i = 32'h0000_123D;
        repeat (4) @(posedge clk);
        @(negedge clk);
        pad_data_i = 32'h0000_123C;
        repeat (4) @(posedge clk);
        #1;
        check("masked_irq", {31'b0, gpio_irq}, 32'h0);
        rd_check("pend0", 5'h14, 32'h0000_0001);
        wr_reg(5'h0C, 32'h0000_0001, 4'b1111);
        check("ie_irq_at_wr", {31'b0, irq_at_ack}, 32'h0);
        check("ie_irq_after", {31'b0, gpio_irq}, 32'h1);
        wr_reg(5'h14, 32'h0000_0001, 4'b0010);
        rd_check("pend0_be_off", 5'h14, 32'h0000_0001);
        wr_reg(5'h14, 32'h0000_0001, 4'b0001);
        check("irq0_cleared", {31'b0, gpio_irq}, 32'h0);

        // Collision: W1C lands on the edge that sets pin 5
        @(negedge clk);
        pad_data_i = 32'h0000_121C;
        repeat (2) @(posedge clk);
        wr_reg(5'h14, 32'h0000_0020, 4'b1111);
        rd_check("collide", 5'h14, 32'h0000_0020);
        wr_reg(5'h14, 32'h0000_0020, 4'b1111);
        rd_check("collide_clr", 5'h14, 32'h0);

        // Reserved offsets and read-only IN
        wr_reg(5'h18, 32'hFFFF_FFFF, 4'b1111);
        rd_check("rsv18", 5'h18, 32'h0);
        rd_check("rsv1c", 5'h1C, 32'h0);
        wr_reg(5'h00, 32'hFFFF_FFFF, 4'b1111);
        rd_check("in_ro", 5'h00, 32'h0000_121C);
        rd_check("out_keep", 5'h04, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
